fft_frame_ctrl: RTL and testbench

//  Frame sequencer for the parallel radix-2 DIT FFT core. Collects a serial complex

---
 rtl/fft_frame_ctrl.sv | 109 ++++++++++
 tb/tb_fft_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the parallel radix-2 FFT core: serial fill, parallel
// presentation, latency wait, result capture and valid/ready bin drain.
module fft_frame_ctrl #(
    parameter int SIZE    = 64,
    parameter int RN      = 16,
    parameter int FFT_LAT = $clog2(SIZE) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [RN-1:0]                 in_re,
    input  logic [RN-1:0]                 in_im,
    output logic [SIZE-1:0][1:0][RN-1:0]  fft_in,
    input  logic [SIZE-1:0][1:0][RN-1:0]  fft_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [RN-1:0]                 out_re,
    output logic [RN-1:0]                 out_im,
    output logic [$clog2(SIZE)-1:0]       out_idx,
    output logic                          out_last,
    output logic                          busy
);

    localparam int IW = $clog2(SIZE);
    localparam int CW = $clog2(FFT_LAT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(FFT_LAT);

    typedef enum logic {S_FILL, S_WAIT}  in_state_t;
    typedef enum logic {S_IDLE, S_DRAIN} out_state_t;

    in_state_t                    r_in_st,  w_in_nxt;
    out_state_t                   r_out_st, w_out_nxt;
    logic [IW-1:0]                r_wr_idx;
    logic [IW-1:0]                r_rd_idx;
    logic [CW-1:0]                r_cnt;
    logic [SIZE-1:0][1:0][RN-1:0] r_frame;
    logic [SIZE-1:0][1:0][RN-1:0] r_result;

    logic w_accept;
    logic w_capture;
    logic w_hs;
    logic w_rd_last;
    logic w_wr_last;

    always_comb begin
        w_in_nxt  = r_in_st;
        w_out_nxt = r_out_st;
        w_accept  = (r_in_st == S_FILL) && in_valid;
        w_wr_last = (r_wr_idx == LAST_IDX);
        w_rd_last = (r_rd_idx == LAST_IDX);
        // Capture only when the drain side is idle, so results are never overwritten mid-drain.
        w_capture = (r_in_st == S_WAIT) && (r_cnt == '0) && (r_out_st == S_IDLE);
        w_hs      = (r_out_st == S_DRAIN) && out_ready;

        case (r_in_st)
            S_FILL:  if (w_accept && w_wr_last) w_in_nxt = S_WAIT;
            S_WAIT:  if (w_capture) w_in_nxt = S_FILL;
            default: w_in_nxt = S_FILL;
        endcase

        case (r_out_st)
            S_IDLE:  if (w_capture) w_out_nxt = S_DRAIN;
            S_DRAIN: if (w_hs && w_rd_last) w_out_nxt = S_IDLE;
            default: w_out_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_st  <= S_FILL;
            r_out_st <= S_IDLE;
        end else begin
            r_in_st  <= w_in_nxt;
            r_out_st <= w_out_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_cnt    <= '0;
            r_frame  <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_frame[r_wr_idx][0] <= in_re;
                r_frame[r_wr_idx][1] <= in_im;
                r_wr_idx <= w_wr_last ? '0 : r_wr_idx + 1'b1;
                if (w_wr_last) r_cnt <= LAT_INIT;
            end
            if ((r_in_st == S_WAIT) && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
            if (w_capture) r_result <= fft_out;
            if (w_hs) r_rd_idx <= w_rd_last ? '0 : r_rd_idx + 1'b1;
        end
    end

    assign fft_in    = r_frame;
    assign in_ready  = (r_in_st == S_FILL);
    assign out_valid = (r_out_st == S_DRAIN);
    assign out_re    = out_valid ? r_result[r_rd_idx][0] : '0;
    assign out_im    = out_valid ? r_result[r_rd_idx][1] : '0;
    assign out_idx   = r_rd_idx;
    assign out_last  = out_valid && w_rd_last;
    assign busy      = !((r_in_st == S_FILL) && (r_wr_idx == '0) && (r_out_st == S_IDLE));

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl with a Walsh-Hadamard stand-in core of FFT_LAT stages;
// a frame-level scoreboard predicts bins, capture edges and in_ready.
`timescale 1ns/1ps
module tb_fft_frame_ctrl;

    localparam int SIZE = 8;
    localparam int RN   = 16;
    localparam int LAT  = 4;

    typedef logic [SIZE-1:0][1:0][RN-1:0] frame_t;
    typedef struct {
        logic [RN-1:0] re;
        logic [RN-1:0] im;
        int            idx;
    } bin_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [RN-1:0] in_re;
    logic [RN-1:0] in_im;
    frame_t        fft_in;
    frame_t        fft_out;
    logic          out_valid;
    logic          out_ready;
    logic [RN-1:0] out_re;
    logic [RN-1:0] out_im;
    logic [2:0]    out_idx;
    logic          out_last;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_mode = 1;

    fft_frame_ctrl #(.SIZE(SIZE), .RN(RN), .FFT_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .fft_in(fft_in), .fft_out(fft_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stand-in core: in-place butterfly Walsh-Hadamard transform, LAT register stages.
    function automatic frame_t core_wht(input frame_t f);
        int     re[SIZE];
        int     im[SIZE];
        int     a;
        frame_t r;
        for (int k = 0; k < SIZE; k++) begin
            re[k] = int'($signed(f[k][0]));
            im[k] = int'($signed(f[k][1]));
        end
        for (int h = 1; h < SIZE; h = h * 2)
            for (int i = 0; i < SIZE; i += 2 * h)
                for (int j = i; j < i + h; j++) begin
                    a = re[j]; re[j] = a + re[j+h]; re[j+h] = a - re[j+h];
                    a = im[j]; im[j] = a + im[j+h]; im[j+h] = a - im[j+h];
                end
        for (int k = 0; k < SIZE; k++) begin
            r[k][0] = 16'(re[k]);
            r[k][1] = 16'(im[k]);
        end
        return r;
    endfunction

    frame_t pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= core_wht(fft_in);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign fft_out = pipe[LAT-1];

    // Scoreboard, sampled on the falling edge: the values seen here are those the next rising edge uses.
    int   cur_re[$];
    int   cur_im[$];
    bin_t exp_q[$];
    int   t_q[$];
    int   last_drain = -1000;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic [RN-1:0] prev_re, prev_im;
    logic [2:0]    prev_idx;
    int   t_done, e_cap, sr, si;
    bin_t b;

    always @(negedge clk) begin
        if (reset) begin
            cur_re.delete(); cur_im.delete(); exp_q.delete(); t_q.delete();
            last_drain = -1000;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", out_valid, 1);
                check("hold_re", out_re, prev_re);
                check("hold_im", out_im, prev_im);
                check("hold_idx", out_idx, prev_idx);
            end
            if (out_valid && !prev_valid) begin
                if (t_q.size() == 0) check("unexpected_capture", 1, 0);
                else begin
                    t_done = t_q.pop_front();
                    e_cap  = t_done + LAT + 1;
                    if (last_drain + 1 > e_cap) e_cap = last_drain + 1;
                    check("capture_edge", cyc, e_cap);
                end
            end
            check("in_ready", in_ready, t_q.size() == 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("stale_bin", 1, 0);
                else begin
                    b = exp_q.pop_front();
                    check("bin_re", out_re, b.re);
                    check("bin_im", out_im, b.im);
                    check("bin_idx", out_idx, b.idx);
                    check("bin_last", out_last, b.idx == SIZE - 1);
                    if (b.idx == SIZE - 1) last_drain = cyc + 1;
                end
            end
            if (in_valid && in_ready) begin
                cur_re.push_back(int'($signed(in_re)));
                cur_im.push_back(int'($signed(in_im)));
                if (cur_re.size() == SIZE) begin
                    for (int k = 0; k < SIZE; k++) begin
                        sr = 0; si = 0;
                        for (int n = 0; n < SIZE; n++) begin
                            if ($countones(k & n) % 2 == 1) begin
                                sr -= cur_re[n]; si -= cur_im[n];
                            end else begin
                                sr += cur_re[n]; si += cur_im[n];
                            end
                        end
                        b.re = sr[15:0]; b.im = si[15:0]; b.idx = k;
                        exp_q.push_back(b);
                    end
                    t_q.push_back(cyc + 1);
                    cur_re.delete(); cur_im.delete();
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_re = out_re; prev_im = out_im; prev_idx = out_idx;
        end
    end

    task automatic tick();
        if (ready_mode == 2) out_ready = 1'($urandom % 2);
        else out_ready = (ready_mode == 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int re_v[SIZE], input int im_v[SIZE], input bit gappy);
        int   k = 0;
        int   guard = 0;
        logic acc;
        while (k < SIZE && guard < 300) begin
            in_valid = gappy ? 1'($urandom % 2) : 1'b1;
            in_re = 16'(re_v[k]);
            in_im = 16'(im_v[k]);
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
            guard++;
        end
        in_valid = 1'b0;
        if (k < SIZE) check("send_timeout", k, SIZE);
    endtask

    task automatic rand_frame(output int re_v[SIZE], output int im_v[SIZE]);
        for (int i = 0; i < SIZE; i++) begin
            re_v[i] = int'($urandom_range(0, 4000)) - 2000;
            im_v[i] = int'($urandom_range(0, 4000)) - 2000;
        end
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while ((busy || out_valid) && g < 500) begin
            tick();
            g++;
        end
        check(tag, busy, 0);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    int dc_re[SIZE], zero_v[SIZE], imp_re[SIZE], r_re[SIZE], r_im[SIZE];
    int g;
    logic [RN-1:0] d_re, d_im;

    initial begin
        for (int i = 0; i < SIZE; i++) begin
            dc_re[i] = 16; zero_v[i] = 0; imp_re[i] = (i == 0) ? 256 : 0;
        end
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_fft_in", fft_in != '0, 0);

        ready_mode = 1;
        send_frame(dc_re, zero_v, 1'b0);
        wait_idle("dc_done");
        send_frame(imp_re, zero_v, 1'b0);
        wait_idle("impulse_done");

        ready_mode = 0;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            d_re = 16'($urandom_range(0, 4000) - 2000);
            d_im = 16'($urandom_range(0, 4000) - 2000);
            in_re = d_re; in_im = d_im;
            tick();
        end
        in_valid = 1'b0;
        check("bp_out_valid", out_valid, 1);
        check("bp_out_idx", out_idx, 0);
        check("bp_in_ready", in_ready, 0);
        ready_mode = 1;
        wait_idle("bp_done");

        ready_mode = 2;
        send_frame(dc_re, zero_v, 1'b1);
        send_frame(imp_re, zero_v, 1'b1);
        for (int f = 0; f < 3; f++) begin
            rand_frame(r_re, r_im);
            send_frame(r_re, r_im, 1'b1);
        end
        wait_idle("gappy_done");

        ready_mode = 1;
        for (int f = 0; f < 4; f++) begin
            rand_frame(r_re, r_im);
            send_frame(r_re, r_im, 1'b0);
        end
        wait_idle("stream_done");

        send_frame(imp_re, zero_v, 1'b0);
        g = 0;
        while (!(out_valid && out_idx == 3) && g < 100) begin
            tick();
            g++;
        end
        check("reach_idx3", out_valid && out_idx == 3, 1);
        #1 reset = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_in_ready", in_ready, 1);
        check("async_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("post_rst_out_valid", out_valid, 0);
        rand_frame(r_re, r_im);
        send_frame(r_re, r_im, 1'b0);
        wait_idle("post_rst_done");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
